// File: rtl/mux_8x1_pkg.sv
// mux_8x1_pkg
//   Shared constants, types and helpers for the registered 8-to-1 mux.
//   Contents:
//     N_LANES    - number of input lanes (8)
//     SEL_W      - width of the lane index (3)
//     sel_t      - lane index type
//     onehot_of  - converts a lane index into an 8-bit one-hot vector
package mux_8x1_pkg;

  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;

  typedef logic [SEL_W-1:0] sel_t;

  // Bit k of the result is set when s == k; every other bit is clear.
  function automatic logic [N_LANES-1:0] onehot_of(input sel_t s);
    logic [N_LANES-1:0] result;
    result    = '0;
    result[s] = 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/mux_8x1_if.sv
// mux_8x1_if
//   Bundles the lane bus, select and valid qualifiers of the 8-to-1 mux.
//   Parameter:
//     DATA_W    - width of one lane and of the output
//   Signals:
//     in        - packed lanes, lane k = in[k*DATA_W +: DATA_W]
//     sel       - lane index 0..7
//     in_valid  - qualifies in/sel for the current cycle
//     out       - registered selected lane
//     out_valid - out was captured on the previous clock edge
//   Modports:
//     master    - drives in/sel/in_valid, observes out/out_valid
//     slave     - the mux side: consumes in/sel/in_valid, drives out/out_valid
interface mux_8x1_if #(
  parameter int DATA_W = 1
) ();
  import mux_8x1_pkg::*;

  logic [N_LANES*DATA_W-1:0] in;
  sel_t                      sel;
  logic                      in_valid;
  logic [DATA_W-1:0]         out;
  logic                      out_valid;

  modport master (
    output in,
    output sel,
    output in_valid,
    input  out,
    input  out_valid
  );

  modport slave (
    input  in,
    input  sel,
    input  in_valid,
    output out,
    output out_valid
  );

endinterface

// File: rtl/mux_8x1_core.sv
// mux_8x1_core
//   Purely combinational lane selector: lane = in[sel*DATA_W +: DATA_W].
//   Lane 0 occupies the least significant DATA_W bits of in.
//   Ports:
//     in   - packed lanes (N_LANES*DATA_W bits)
//     sel  - lane index 0..7
//     lane - the selected lane (DATA_W bits)
module mux_8x1_core
  import mux_8x1_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [N_LANES*DATA_W-1:0] in,
  input  sel_t                      sel,
  output logic [DATA_W-1:0]         lane
);

  // Unpacking into an array keeps the select a plain array index, which
  // maps onto a single mux tree per output bit.
  logic [DATA_W-1:0] lanes [N_LANES];

  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_unpack
      assign lanes[gi] = in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Every 3-bit code addresses a real lane, so no default is needed.
  assign lane = lanes[sel];

endmodule

// File: rtl/mux_8x1.sv
// mux_8x1
//   Registered 8-to-1 multiplexer with a valid qualifier.
//   Each rising edge with in_valid=1 captures lane[sel] into out and raises
//   out_valid; an edge with in_valid=0 holds out and drops out_valid.
//   Synchronous active-high reset clears both registers and wins over
//   in_valid, so a capture pending at the reset edge is discarded.
//   Parameter:
//     DATA_W     - lane / output width (must match the bus interface)
//   Ports:
//     clk        - rising-edge clock
//     rst        - synchronous active-high reset
//     bus        - mux_8x1_if slave modport (in, sel, in_valid, out, out_valid)
//   Optional build macro MUX_8X1_COMB_OUT_EN adds:
//     out_comb   - lane[sel], combinational, zero latency
//     sel_onehot - 1 << sel, combinational
//   The registered path behaves identically with or without the macro.
module mux_8x1
  import mux_8x1_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  mux_8x1_if.slave           bus
`ifdef MUX_8X1_COMB_OUT_EN
  ,
  output logic [DATA_W-1:0]  out_comb,
  output logic [N_LANES-1:0] sel_onehot
`endif
);

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] out_reg;
  logic              out_valid_reg;

  // Single selector instance shared by the output register and the
  // optional combinational tap.
  mux_8x1_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .in   (bus.in),
    .sel  (bus.sel),
    .lane (lane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      // out_valid is a one-cycle freshness flag; out itself only moves
      // on a qualified cycle so idle input activity never reaches it.
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        out_reg <= lane;
      end
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;

`ifdef MUX_8X1_COMB_OUT_EN
  assign out_comb   = lane;
  assign sel_onehot = onehot_of(bus.sel);
`endif

endmodule

// File: tb/tb_mux_8x1.sv
// tb_mux_8x1
//   Self-checking bench for mux_8x1. Two instances are exercised: DATA_W=1
//   (bit lanes) and DATA_W=8 (byte lanes). Expected results are pushed to a
//   queue when a qualified input is driven and popped when the output is due.
//   With MUX_8X1_COMB_OUT_EN defined, the combinational taps are also checked.
module tb_mux_8x1;
  import mux_8x1_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_8x1_if #(.DATA_W(1)) bus1 ();
  mux_8x1_if #(.DATA_W(8)) bus8 ();

`ifdef MUX_8X1_COMB_OUT_EN
  logic [0:0] out_comb1;
  logic [7:0] sel_onehot1;
  logic [7:0] out_comb8;
  logic [7:0] sel_onehot8;
`endif

  mux_8x1 #(.DATA_W(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus1.slave)
`ifdef MUX_8X1_COMB_OUT_EN
    ,
    .out_comb   (out_comb1),
    .sel_onehot (sel_onehot1)
`endif
  );

  mux_8x1 #(.DATA_W(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus8.slave)
`ifdef MUX_8X1_COMB_OUT_EN
    ,
    .out_comb   (out_comb8),
    .sel_onehot (sel_onehot8)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic       q1 [$];
  logic [7:0] q8 [$];

  // Byte-lane pattern: lane k holds 8'h10 + k.
  logic [63:0] byte_pattern;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the 1-bit instance; a qualified cycle outside reset queues its result.
  task automatic drive1(input logic [7:0] d, input logic [2:0] s, input logic v);
    bus1.in       = d;
    bus1.sel      = s;
    bus1.in_valid = v;
    if (v && !rst) q1.push_back(d[s]);
  endtask

  // Drive the byte instance; the expected byte is derived from the pattern rule.
  task automatic drive8(input logic [2:0] s, input logic v);
    bus8.in       = byte_pattern;
    bus8.sel      = s;
    bus8.in_valid = v;
    if (v && !rst) q8.push_back(8'h10 + {5'd0, s});
  endtask

  function automatic logic pop1();
    if (q1.size() == 0) return 1'bx;
    return q1.pop_front();
  endfunction

  function automatic logic [7:0] pop8();
    if (q8.size() == 0) return 8'hxx;
    return q8.pop_front();
  endfunction

  task automatic test_reset();
    logic e;
    rst = 1'b1;
    drive1(8'hFF, 3'd7, 1'b1);
    drive8(3'd5, 1'b1);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if (bus1.out !== 1'b0 || bus1.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold1 cyc%0d: out=%b out_valid=%b, required out=0 out_valid=0",
                 c, bus1.out, bus1.out_valid);
      end
      n_vec++;
      if (bus8.out !== 8'h00 || bus8.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold8 cyc%0d: out=%h out_valid=%b, required out=00 out_valid=0",
                 c, bus8.out, bus8.out_valid);
      end
    end
    rst = 1'b0;
    drive1(8'hFF, 3'd7, 1'b1);
    drive8(3'd5, 1'b1);
    tick();
    e = pop1();
    n_vec++;
    if (bus1.out_valid !== 1'b1 || bus1.out !== e) begin
      n_err++;
      $display("FAIL reset_first_valid: out=%b out_valid=%b, required out=%b out_valid=1",
               bus1.out, bus1.out_valid, e);
    end
    n_vec++;
    if (bus8.out_valid !== 1'b1 || bus8.out !== pop8()) begin
      n_err++;
      $display("FAIL reset_first_valid8: out=%h out_valid=%b, required out=15 out_valid=1",
               bus8.out, bus8.out_valid);
    end
    drive1(8'h00, 3'd0, 1'b0);
    drive8(3'd0, 1'b0);
    tick();
    n_vec++;
    if (bus1.out_valid !== 1'b0 || bus1.out !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle_after: out=%b out_valid=%b, required out=1 out_valid=0",
               bus1.out, bus1.out_valid);
    end
  endtask

  task automatic test_sweep();
    logic        e;
    logic [7:0]  literal_seq;
    literal_seq = 8'b01100110;  // read bit s: 0,1,1,0,0,1,1,0 for s = 0..7
    for (int s = 0; s < 8; s++) begin
      drive1(8'b01100110, s[2:0], 1'b1);
      tick();
      e = pop1();
      n_vec++;
      if (bus1.out_valid !== 1'b1 || bus1.out !== e || bus1.out !== literal_seq[s]) begin
        n_err++;
        $display("FAIL sweep sel=%0d: out=%b out_valid=%b, required out=%b out_valid=1",
                 s, bus1.out, bus1.out_valid, literal_seq[s]);
      end
    end
    drive1(8'h00, 3'd0, 1'b0);
    tick();
    n_vec++;
    if (bus1.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_tail: out_valid=%b, required 0", bus1.out_valid);
    end
  endtask

  task automatic test_lane_isolation();
    logic [7:0] vin [3];
    logic [2:0] vsel [3];
    logic       vexp [3];
    logic       e;
    logic [7:0] d;
    vin[0] = 8'b00000000; vsel[0] = 3'b101; vexp[0] = 1'b0;
    vin[1] = 8'b00000001; vsel[1] = 3'b000; vexp[1] = 1'b1;
    vin[2] = 8'b00100010; vsel[2] = 3'b001; vexp[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive1(vin[i], vsel[i], 1'b1);
      tick();
      e = pop1();
      n_vec++;
      if (bus1.out_valid !== 1'b1 || bus1.out !== vexp[i] || e !== vexp[i]) begin
        n_err++;
        $display("FAIL isolation%0d in=%b sel=%0d: out=%b out_valid=%b, required %b",
                 i, vin[i], vsel[i], bus1.out, bus1.out_valid, vexp[i]);
      end
    end
    // Selected lane alone set, then every other lane set: out follows only lane s.
    for (int s = 0; s < 8; s++) begin
      for (int pol = 0; pol < 2; pol++) begin
        d = 8'd1 << s;
        if (pol == 1) d = ~d;
        drive1(d, s[2:0], 1'b1);
        tick();
        e = pop1();
        n_vec++;
        if (bus1.out !== e || bus1.out !== (pol == 0)) begin
          n_err++;
          $display("FAIL isolation_walk sel=%0d in=%b: out=%b, required %b",
                   s, d, bus1.out, (pol == 0));
        end
      end
    end
  endtask

  task automatic test_hold();
    logic e;
    drive1(8'b01100110, 3'b010, 1'b1);
    tick();
    e = pop1();
    n_vec++;
    if (bus1.out !== 1'b1 || e !== 1'b1 || bus1.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL hold_capture: out=%b out_valid=%b, required out=1 out_valid=1",
               bus1.out, bus1.out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      drive1(8'h00, c[2:0] + 3'd3, 1'b0);
      tick();
      n_vec++;
      if (bus1.out !== 1'b1 || bus1.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold_idle cyc%0d: out=%b out_valid=%b, required out=1 out_valid=0",
                 c, bus1.out, bus1.out_valid);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic e;
    drive1(8'hFF, 3'd4, 1'b1);
    tick();
    e = pop1();
    n_vec++;
    if (bus1.out !== e || bus1.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre: out=%b out_valid=%b, required out=1 out_valid=1",
               bus1.out, bus1.out_valid);
    end
    rst = 1'b1;
    drive1(8'hFF, 3'd4, 1'b1);
    tick();
    n_vec++;
    if (bus1.out !== 1'b0 || bus1.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_discard: out=%b out_valid=%b, required out=0 out_valid=0",
               bus1.out, bus1.out_valid);
    end
    rst = 1'b0;
    drive1(8'hFF, 3'd4, 1'b0);
    tick();
  endtask

  task automatic test_width();
    logic [2:0] order [4];
    logic [7:0] e;
    order[0] = 3'd6; order[1] = 3'd0; order[2] = 3'd7; order[3] = 3'd3;
    for (int i = 0; i < 4; i++) begin
      drive8(order[i], 1'b1);
      tick();
      e = pop8();
      n_vec++;
      if (bus8.out_valid !== 1'b1 || bus8.out !== e) begin
        n_err++;
        $display("FAIL width sel=%0d: out=%h out_valid=%b, required out=%h out_valid=1",
                 order[i], bus8.out, bus8.out_valid, e);
      end
    end
    drive8(3'd1, 1'b0);
    tick();
    n_vec++;
    if (bus8.out !== 8'h13 || bus8.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL width_hold: out=%h out_valid=%b, required out=13 out_valid=0",
               bus8.out, bus8.out_valid);
    end
  endtask

`ifdef MUX_8X1_COMB_OUT_EN
  task automatic test_comb_out();
    logic e;
    drive1(8'b01100110, 3'b011, 1'b1);
    #1;
    n_vec++;
    if (out_comb1 !== 1'b0 || sel_onehot1 !== 8'b00001000) begin
      n_err++;
      $display("FAIL comb_same_cycle: out_comb=%b sel_onehot=%b, required 0 00001000",
               out_comb1, sel_onehot1);
    end
    tick();
    e = pop1();
    n_vec++;
    if (bus1.out !== e || bus1.out !== 1'b0 || bus1.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL comb_registered: out=%b out_valid=%b, required out=0 out_valid=1",
               bus1.out, bus1.out_valid);
    end
    // Combinational taps follow sel even with in_valid low.
    for (int s = 0; s < 8; s++) begin
      drive8(s[2:0], 1'b0);
      #1;
      n_vec++;
      if (out_comb8 !== 8'h10 + s[7:0] || sel_onehot8 !== (8'd1 << s)) begin
        n_err++;
        $display("FAIL comb8 sel=%0d: out_comb=%h sel_onehot=%b", s, out_comb8, sel_onehot8);
      end
    end
    drive1(8'h00, 3'd0, 1'b0);
    tick();
  endtask
`endif

  initial begin
    for (int k = 0; k < 8; k++) byte_pattern[k*8 +: 8] = 8'h10 + k[7:0];
    rst = 1'b1;
    drive1(8'h00, 3'd0, 1'b0);
    drive8(3'd0, 1'b0);

    test_reset();
    test_sweep();
    test_lane_isolation();
    test_hold();
    test_reset_midstream();
    test_width();
`ifdef MUX_8X1_COMB_OUT_EN
    test_comb_out();
`endif

    n_vec++;
    if (q1.size() != 0 || q8.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", q1.size(), q8.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
